// File: rtl/mult_pkg.sv
// Shared types and widths for the multiplier-sharing arbiter and its round-robin picker.
package mult_pkg;

  localparam int MUL_W    = 18;
  localparam int PROD_W   = 36;
  // Tag id is sized for the largest supported requester count (8).
  localparam int ID_MAX_W = 3;

  typedef struct packed {
    logic                vld;
    logic [ID_MAX_W-1:0] id;
  } mul_tag_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, ascending with wrap.
module rr_pick
  import mult_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  winner,
  output logic            any
);

  always_comb begin
    int idx;
    gnt    = '0;
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        winner   = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/mult_share_arb.sv
// Round-robin sharing of one signed 18x18 multiplier; a tag pipeline matched to the
// multiplier latency routes each product back to the requester that issued it.
module mult_share_arb
  import mult_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int LAT  = 1,
  localparam int IDW  = clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*MUL_W-1:0]  req_a,
  input  logic [NREQ*MUL_W-1:0]  req_b,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [PROD_W-1:0]      rsp_p,
  output logic                   busy,
  output logic [MUL_W-1:0]       mul_a,
  output logic [MUL_W-1:0]       mul_b,
  output logic                   mul_en,
  output logic                   mul_rst,
  input  logic [PROD_W-1:0]      mul_p
);

  logic [IDW-1:0]   rr_ptr_reg;
  logic [NREQ-1:0]  pick_gnt;
  logic [IDW-1:0]   winner;
  logic             pick_any;
  logic             xfer;
  logic [MUL_W-1:0] op_a [NREQ];
  logic [MUL_W-1:0] op_b [NREQ];

  mul_tag_t [LAT-1:0] tag_reg;
  mul_tag_t [LAT-1:0] tag_next;
  logic     [LAT-1:0] tag_vld;
  logic               final_vld;

  logic [NREQ-1:0]    rsp_valid_reg;
  logic [NREQ-1:0]    rsp_valid_next;
  logic [PROD_W-1:0]  rsp_p_reg;
  logic               mul_rst_reg;

  genvar gi;

  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign op_a[gi] = req_a[gi*MUL_W +: MUL_W];
      assign op_b[gi] = req_b[gi*MUL_W +: MUL_W];
    end
  endgenerate

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (req_valid),
    .ptr    (rr_ptr_reg),
    .gnt    (pick_gnt),
    .winner (winner),
    .any    (pick_any)
  );

  // The picker only selects asserted requests, so any grant is also a transfer.
  assign xfer      = pick_any & ~clear & rst_n;
  assign req_ready = xfer ? pick_gnt : '0;
  assign mul_a     = xfer ? op_a[winner] : '0;
  assign mul_b     = xfer ? op_b[winner] : '0;
  assign mul_en    = rst_n;
  assign mul_rst   = mul_rst_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg <= '0;
    end else if (xfer) begin
      rr_ptr_reg <= (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
    end
  end

  // Tag stages shift every cycle; clear drops every valid bit so in-flight products die.
  assign tag_next[0] = {xfer, ID_MAX_W'(winner)};
  generate
    for (gi = 1; gi < LAT; gi++) begin : g_shift
      assign tag_next[gi] = {tag_reg[gi-1].vld & ~clear, tag_reg[gi-1].id};
    end
    for (gi = 0; gi < LAT; gi++) begin : g_vld
      assign tag_vld[gi] = tag_reg[gi].vld;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tag_reg <= '0;
    else        tag_reg <= tag_next;
  end

  assign final_vld = tag_reg[LAT-1].vld & ~clear;

  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_rsp_dec
      assign rsp_valid_next[gi] = final_vld && (tag_reg[LAT-1].id == ID_MAX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_reg <= '0;
      rsp_p_reg     <= '0;
      mul_rst_reg   <= 1'b0;
    end else begin
      rsp_valid_reg <= rsp_valid_next;
      mul_rst_reg   <= clear;
      if (final_vld) rsp_p_reg <= mul_p;
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_p     = rsp_p_reg;
  assign busy      = (|tag_vld) | (|rsp_valid_reg);

endmodule

// File: tb/tb_mult_share_arb.sv
// Scoreboard bench: LAT=1 and LAT=3 instances share stimulus; each has its own multiplier model.
module tb_mult_share_arb;

  typedef struct {
    int          id;
    logic [35:0] prod;
    int          due;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clear = 1'b0;
  logic [3:0]  req_valid = 4'b0;
  logic [71:0] req_a, req_b;

  logic signed [17:0] op_a [4];
  logic signed [17:0] op_b [4];
  logic [35:0]        op_p [4];

  int exp_gnt = -1;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  sb_t sbq [2][$];

  logic [3:0]  rdy1, rv1, rdy3, rv3;
  logic [35:0] rp1, rp3, mp1;
  logic        busy1, busy3, men1, men3, mrst1, mrst3;
  logic [17:0] ma1, mb1, ma3, mb3;
  logic signed [35:0] mpipe1;
  logic signed [35:0] mpipe3 [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < 4; i++) begin
      req_a[i*18 +: 18] = op_a[i];
      req_b[i*18 +: 18] = op_b[i];
    end
  end

  mult_share_arb #(.NREQ(4), .LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .req_valid(req_valid), .req_ready(rdy1),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rv1), .rsp_p(rp1), .busy(busy1),
    .mul_a(ma1), .mul_b(mb1), .mul_en(men1), .mul_rst(mrst1), .mul_p(mp1)
  );

  mult_share_arb #(.NREQ(4), .LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .req_valid(req_valid), .req_ready(rdy3),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rv3), .rsp_p(rp3), .busy(busy3),
    .mul_a(ma3), .mul_b(mb3), .mul_en(men3), .mul_rst(mrst3), .mul_p(mpipe3[2])
  );

  // Multiplier models: CE-gated pipeline with synchronous reset.
  always @(posedge clk) begin
    if (mrst1)     mpipe1 <= '0;
    else if (men1) mpipe1 <= $signed(ma1) * $signed(mb1);
  end
  assign mp1 = mpipe1;

  always @(posedge clk) begin
    if (mrst3) begin
      mpipe3[0] <= '0; mpipe3[1] <= '0; mpipe3[2] <= '0;
    end else if (men3) begin
      mpipe3[0] <= $signed(ma3) * $signed(mb3);
      mpipe3[1] <= mpipe3[0];
      mpipe3[2] <= mpipe3[1];
    end
  end

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, want);
    end
  endtask

  task automatic mon_rsp(input int k, input int lat, input logic [3:0] rv, input logic [35:0] rp);
    sb_t e;
    while (sbq[k].size() > 0 && sbq[k][0].due < cyc) begin
      e = sbq[k].pop_front();
      checks++;
      errors++;
      $display("FAIL rsp_missing lat%0d got=none want=id%0d p=%h at cyc %0d", lat, e.id, e.prod, e.due);
    end
    if (rv !== 4'b0) begin
      checks++;
      if (sbq[k].size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected lat%0d got=rv%b p=%h want=none cyc=%0d", lat, rv, rp, cyc);
      end else begin
        e = sbq[k].pop_front();
        if (rv !== 4'(1 << e.id) || rp !== e.prod || e.due != cyc) begin
          errors++;
          $display("FAIL rsp lat%0d got=rv%b p=%h cyc=%0d want=rv%b p=%h cyc=%0d",
                   lat, rv, rp, cyc, 4'(1 << e.id), e.prod, e.due);
        end else begin
          $display("rsp lat%0d id=%0d p=%h cyc=%0d", lat, e.id, rp, cyc);
        end
      end
    end
    // A clear in this cycle kills everything not yet presented.
    if (clear) begin
      while (sbq[k].size() > 0 && sbq[k][$].due > cyc) void'(sbq[k].pop_back());
    end
  endtask

  task automatic mon_gnt(input int k, input int lat, input logic [3:0] rdy,
                         input logic [17:0] ma, input logic [17:0] mb);
    logic [3:0]  wr;
    logic [17:0] wa, wb;
    wr = '0; wa = '0; wb = '0;
    if (exp_gnt >= 0) begin
      wr = 4'(1 << exp_gnt);
      wa = op_a[exp_gnt];
      wb = op_b[exp_gnt];
    end
    checks++;
    if (rdy !== wr || ma !== wa || mb !== wb) begin
      errors++;
      $display("FAIL grant lat%0d cyc=%0d got=rdy%b a=%h b=%h want=rdy%b a=%h b=%h",
               lat, cyc, rdy, ma, mb, wr, wa, wb);
    end
    if (exp_gnt >= 0) sbq[k].push_back('{id: exp_gnt, prod: op_p[exp_gnt], due: cyc + lat + 1});
  endtask

  always @(negedge clk) begin
    mon_rsp(0, 1, rv1, rp1);
    mon_rsp(1, 3, rv3, rp3);
    mon_gnt(0, 1, rdy1, ma1, mb1);
    mon_gnt(1, 3, rdy3, ma3, mb3);
  end

  task automatic step(input logic [3:0] v, input int g, input logic c);
    @(posedge clk);
    #1;
    req_valid = v;
    exp_gnt   = g;
    clear     = c;
  endtask

  task automatic idle(input int n);
    repeat (n) step(4'b0, -1, 1'b0);
  endtask

  task automatic set_op(input int i, input logic signed [17:0] a, input logic signed [17:0] b,
                        input logic [35:0] p);
    op_a[i] = a;
    op_b[i] = b;
    op_p[i] = p;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_rdy1"},  36'(rdy1),  36'd0);
    chk({tag, "_rv1"},   36'(rv1),   36'd0);
    chk({tag, "_rp1"},   rp1,        36'd0);
    chk({tag, "_busy1"}, 36'(busy1), 36'd0);
    chk({tag, "_men1"},  36'(men1),  36'd0);
    chk({tag, "_rdy3"},  36'(rdy3),  36'd0);
    chk({tag, "_rv3"},   36'(rv3),   36'd0);
    chk({tag, "_rp3"},   rp3,        36'd0);
    chk({tag, "_busy3"}, 36'(busy3), 36'd0);
    chk({tag, "_men3"},  36'(men3),  36'd0);
  endtask

  initial begin
    set_op(0, 18'sd2,    18'sd3,    36'd6);
    set_op(1, -18'sd4,   18'sd7,    -36'sd28);
    set_op(2, 18'sd100,  -18'sd100, -36'sd10000);
    set_op(3, -18'sd1,   -18'sd1,   36'd1);
    #1 rst_n = 1'b0;
    #2 chk_quiet("reset");
    step(4'b0, -1, 1'b0);
    step(4'b0, -1, 1'b0);
    rst_n = 1'b1;

    // All four streaming: strict 0,1,2,3 rotation twice.
    for (int i = 0; i < 8; i++) step(4'hF, i % 4, 1'b0);
    idle(5);

    // Single issue from req0.
    step(4'b0001, 0, 1'b0);
    set_op(0, -18'sd3, 18'sd5, 36'hFFFFFFFF1);
    idle(5);

    // Operand extremes, back-to-back on req2.
    step(4'b0100, 2, 1'b0);
    set_op(2, -18'sd131072, -18'sd131072, 36'h400000000);
    step(4'b0100, 2, 1'b0);
    set_op(2, 18'sd131071, -18'sd131072, 36'hC00020000);
    idle(5);
    chk("rsp_p_hold_lat1", rp1, 36'hC00020000);
    chk("rsp_p_hold_lat3", rp3, 36'hC00020000);

    // Pointer fairness: move ptr to 2, then req1+req3 -> 3 first, then 1.
    step(4'b0010, 1, 1'b0);
    step(4'b1010, 3, 1'b0);
    step(4'b0010, 1, 1'b0);
    idle(5);

    // Clear one cycle after an issue: nothing returns, no grant during clear.
    step(4'b0010, 1, 1'b0);
    step(4'b0001, -1, 1'b1);
    chk("mul_rst_pre_lat1", 36'(mrst1), 36'd0);
    step(4'b0000, -1, 1'b0);
    chk("busy_after_clear_lat1", 36'(busy1), 36'd0);
    chk("busy_after_clear_lat3", 36'(busy3), 36'd0);
    chk("mul_rst_lat1", 36'(mrst1), 36'd1);
    chk("mul_rst_lat3", 36'(mrst3), 36'd1);
    idle(6);

    // Reset with three ops in flight in the LAT=3 instance.
    step(4'hF, 2, 1'b0);
    step(4'hF, 3, 1'b0);
    step(4'hF, 0, 1'b0);
    step(4'h0, -1, 1'b0);
    chk("busy_inflight_lat3", 36'(busy3), 36'd1);
    #1;
    rst_n = 1'b0;
    sbq[0].delete();
    sbq[1].delete();
    #1 chk_quiet("midreset");
    step(4'hF, -1, 1'b0);
    step(4'hF, -1, 1'b0);
    step(4'h0, -1, 1'b0);
    rst_n = 1'b1;
    idle(6);
    step(4'hF, 0, 1'b0);
    idle(6);

    chk("sb_empty_lat1", 36'(sbq[0].size()), 36'd0);
    chk("sb_empty_lat3", 36'(sbq[1].size()), 36'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
